// File: rtl/tape_dma_loader.sv
// tape_dma_loader: traps ROM LOAD, spins the CPU on a patch
// and copies the tape image into RAM before releasing it.
module tape_dma_loader #(
   parameter int TAPE_AW = 14,
   parameter int RAM_AW  = 16
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic [15:0]        cpu_addr,
   input  logic               cpu_m1_n,
   input  logic [15:0]        trap_addr,
   input  logic [15:0]        trap_end,
   input  logic [15:0]        return_addr,
   input  logic [RAM_AW-1:0]  load_base,
   input  logic [TAPE_AW:0]   tape_len,
   input  logic               tape_ready,
   output logic [TAPE_AW-1:0] tape_rd_addr,
   input  logic [7:0]         tape_rd_data,
   output logic [RAM_AW-1:0]  ram_wr_addr,
   output logic [7:0]         ram_wr_data,
   output logic               ram_we,
   input  logic               ram_ack,
   output logic               patch_sel,
   output logic [7:0]         patch_data,
   output logic               busy,
   output logic               done,
   output logic               aborted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t state, state_n;

   logic [TAPE_AW:0]   cnt, cnt_n, cnt_inc;
   logic [TAPE_AW-1:0] rd_addr_n;
   logic [RAM_AW-1:0]  wr_addr_n;
   logic [7:0]         wr_data_n;
   logic               we_n, done_n, aborted_n;
   logic               abort_pend, pend_n;
   logic               m1_q, m1_edge, in_win, leave, hit;
   logic [15:0]        k;

   assign m1_edge = m1_q & ~cpu_m1_n;
   assign in_win  = (cpu_addr >= trap_addr) && (cpu_addr < trap_end);
   assign leave   = m1_edge & ~in_win;
   assign hit     = m1_edge && (cpu_addr == trap_addr);
   assign cnt_inc = cnt + 1'b1;
   assign busy    = (state != S_IDLE);

   // k wraps to a large value below trap_addr, so one compare suffices
   assign k         = cpu_addr - trap_addr;
   assign patch_sel = busy && (k < 16'd7);

   always_comb begin
      patch_data = 8'h00;
      if (patch_sel) begin
         case (k[2:0])
            3'd0:    patch_data = 8'hAF;
            3'd1:    patch_data = (state == S_DONE) ? 8'h37 : 8'h00;
            3'd2:    patch_data = 8'h30;
            3'd3:    patch_data = 8'hFD;
            3'd4:    patch_data = 8'hC3;
            3'd5:    patch_data = return_addr[7:0];
            3'd6:    patch_data = return_addr[15:8];
            default: patch_data = 8'h00;
         endcase
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      rd_addr_n = tape_rd_addr;
      wr_addr_n = ram_wr_addr;
      wr_data_n = ram_wr_data;
      we_n      = ram_we;
      pend_n    = abort_pend;
      done_n    = 1'b0;
      aborted_n = 1'b0;
      unique case (state)
         S_IDLE: begin
            pend_n = 1'b0;
            if (hit && tape_ready) begin
               cnt_n = '0;
               if (tape_len == '0) begin
                  state_n = S_DONE;
               end else begin
                  rd_addr_n = '0;
                  state_n   = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            if (leave) begin
               state_n   = S_IDLE;
               aborted_n = 1'b1;
            end else begin
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (leave) begin
               state_n   = S_IDLE;
               aborted_n = 1'b1;
            end else begin
               wr_data_n = tape_rd_data;
               wr_addr_n = load_base + RAM_AW'(cnt);
               we_n      = 1'b1;
               state_n   = S_WRITE;
            end
         end
         S_WRITE: begin
            if (leave) pend_n = 1'b1;
            // an in-flight write always completes before any exit
            if (ram_ack) begin
               we_n  = 1'b0;
               cnt_n = cnt_inc;
               if (abort_pend || leave) begin
                  pend_n    = 1'b0;
                  aborted_n = 1'b1;
                  state_n   = S_IDLE;
               end else if (cnt_inc == tape_len) begin
                  state_n = S_DONE;
               end else begin
                  rd_addr_n = cnt_inc[TAPE_AW-1:0];
                  state_n   = S_FETCH;
               end
            end
         end
         S_DONE: begin
            if (leave) begin
               done_n  = 1'b1;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         cnt          <= '0;
         tape_rd_addr <= '0;
         ram_wr_addr  <= '0;
         ram_wr_data  <= '0;
         ram_we       <= 1'b0;
         done         <= 1'b0;
         aborted      <= 1'b0;
         abort_pend   <= 1'b0;
         m1_q         <= 1'b1;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         tape_rd_addr <= rd_addr_n;
         ram_wr_addr  <= wr_addr_n;
         ram_wr_data  <= wr_data_n;
         ram_we       <= we_n;
         done         <= done_n;
         aborted      <= aborted_n;
         abort_pend   <= pend_n;
         m1_q         <= cpu_m1_n;
      end
   end

endmodule

// File: tb/tb_tape_dma_loader.sv
// tb_tape_dma_loader: random tape loads against a queue-based
// model of the expected RAM writes, pulses and patch bytes.
module tb_tape_dma_loader;
   localparam int TAPE_AW = 4;
   localparam int RAM_AW  = 16;
   localparam int DEPTH   = 1 << TAPE_AW;

   logic               clk_sys = 1'b0;
   logic               reset_n;
   logic [15:0]        cpu_addr;
   logic               cpu_m1_n;
   logic [15:0]        trap_addr, trap_end, return_addr;
   logic [RAM_AW-1:0]  load_base;
   logic [TAPE_AW:0]   tape_len;
   logic               tape_ready;
   logic [TAPE_AW-1:0] tape_rd_addr;
   logic [7:0]         tape_rd_data;
   logic [RAM_AW-1:0]  ram_wr_addr;
   logic [7:0]         ram_wr_data;
   logic               ram_we;
   logic               ram_ack = 1'b0;
   logic               patch_sel;
   logic [7:0]         patch_data;
   logic               busy, done, aborted;

   always #5 clk_sys = ~clk_sys;

   tape_dma_loader #(.TAPE_AW(TAPE_AW), .RAM_AW(RAM_AW)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .cpu_addr(cpu_addr), .cpu_m1_n(cpu_m1_n),
      .trap_addr(trap_addr), .trap_end(trap_end),
      .return_addr(return_addr), .load_base(load_base),
      .tape_len(tape_len), .tape_ready(tape_ready),
      .tape_rd_addr(tape_rd_addr), .tape_rd_data(tape_rd_data),
      .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
      .ram_we(ram_we), .ram_ack(ram_ack),
      .patch_sel(patch_sel), .patch_data(patch_data),
      .busy(busy), .done(done), .aborted(aborted)
   );

   logic [7:0] mem [DEPTH];
   always @(posedge clk_sys) tape_rd_data <= mem[tape_rd_addr];

   logic [15:0] wq_addr [$];
   logic [7:0]  wq_data [$];
   int          wq_cyc  [$];
   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int age = 0;
   int need = 0;
   int stall_idx = -1;
   int stall_len = 0;
   bit rand_ack = 1'b0;
   bit hold_pend = 1'b0;
   logic [15:0] h_addr;
   logic [7:0]  h_data;
   int done_cnt = 0;
   int abort_cnt = 0;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // RAM slave: ack policy, write capture, hold stability, pulses
   always @(negedge clk_sys) begin
      cyc++;
      if (ram_we) begin
         if (hold_pend) begin
            check_eq("hold_addr", 32'(ram_wr_addr), 32'(h_addr));
            check_eq("hold_data", 32'(ram_wr_data), 32'(h_data));
         end
         if (age == 0) begin
            if (wq_addr.size() == stall_idx) need = stall_len;
            else if (rand_ack) need = int'($urandom_range(0, 2));
            else need = 0;
         end
         ram_ack = (age >= need);
         if (ram_ack) begin
            wq_addr.push_back(ram_wr_addr);
            wq_data.push_back(ram_wr_data);
            wq_cyc.push_back(cyc);
            age = 0;
            hold_pend = 1'b0;
         end else begin
            age++;
            hold_pend = 1'b1;
            h_addr = ram_wr_addr;
            h_data = ram_wr_data;
         end
      end else begin
         ram_ack = 1'($urandom_range(0, 1));
         age = 0;
         hold_pend = 1'b0;
      end
      if (done || aborted)
         check_eq("pulse_excl", 32'(done & aborted), 32'd0);
      if (done) done_cnt++;
      if (aborted) abort_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic m1(input logic [15:0] a);
      cpu_addr = a;
      cpu_m1_n = 1'b0;
      tick(1);
      cpu_m1_n = 1'b1;
      tick(1);
   endtask

   task automatic wait_writes(input int n, input int budget);
      int w = 0;
      while (wq_addr.size() < n && w < budget) begin
         tick(1);
         w++;
      end
      check_eq("wait_writes", 32'(wq_addr.size()), 32'(n));
   endtask

   task automatic compare_writes(input int s, input logic [15:0] base,
                                 input int len);
      check_eq("n_writes", 32'(wq_addr.size() - s), 32'(len));
      for (int i = 0; i < len && s + i < wq_addr.size(); i++) begin
         logic [15:0] ea;
         ea = base + 16'(i);
         check_eq("wr_addr", 32'(wq_addr[s+i]), 32'(ea));
         check_eq("wr_data", 32'(wq_data[s+i]), 32'(mem[i]));
      end
   endtask

   task automatic check_patch(input bit in_done);
      logic [7:0] tbl [7];
      tbl = '{8'hAF, 8'h00, 8'h30, 8'hFD, 8'hC3,
              return_addr[7:0], return_addr[15:8]};
      if (in_done) tbl[1] = 8'h37;
      for (int i = 0; i < 8; i++) begin
         cpu_addr = trap_addr + 16'(i);
         #1;
         check_eq("patch_sel", 32'(patch_sel), (i < 7) ? 32'd1 : 32'd0);
         check_eq("patch_data", 32'(patch_data),
                  (i < 7) ? 32'(tbl[i]) : 32'd0);
         tick(1);
      end
   endtask

   task automatic exit_done(input int d0, input int a0);
      m1(16'h0207);
      check_eq("done_pulse", 32'(done_cnt - d0), 32'd1);
      check_eq("no_abort", 32'(abort_cnt - a0), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_rd"}, 32'(tape_rd_addr), 32'd0);
      check_eq({tag, "_wa"}, 32'(ram_wr_addr), 32'd0);
      check_eq({tag, "_wd"}, 32'(ram_wr_data), 32'd0);
      check_eq({tag, "_we"}, 32'(ram_we), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_pulses"}, 32'({done, aborted}), 32'd0);
   endtask

   initial begin
      int s, d0, a0, len, w;
      logic [15:0] base;
      reset_n = 1'b0;
      cpu_addr = 16'h0347;
      cpu_m1_n = 1'b1;
      trap_addr = 16'h0347;
      trap_end = 16'h03C3;
      return_addr = 16'h0207;
      load_base = 16'h4009;
      tape_len = 5'd5;
      tape_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
      tick(3);
      check_reset_vals("reset");
      check_eq("reset_psel", 32'(patch_sel), 32'd0);
      reset_n = 1'b1;
      tick(1);

      // ZX81 .p load, ack always
      s = wq_addr.size(); d0 = done_cnt; a0 = abort_cnt;
      m1(16'h0347);
      check_eq("zx81_busy", 32'(busy), 32'd1);
      check_patch(1'b0);
      wait_writes(s + 5, 100);
      tick(2);
      check_patch(1'b1);
      compare_writes(s, 16'h4009, 5);
      for (int i = 1; i < 5; i++)
         check_eq("zx81_gap", 32'(wq_cyc[s+i] - wq_cyc[s+i-1]), 32'd3);
      exit_done(d0, a0);

      // backpressure on byte 2
      fill_random();
      s = wq_addr.size(); d0 = done_cnt; a0 = abort_cnt;
      base = 16'($urandom); load_base = base; tape_len = 5'd6;
      stall_idx = s + 2; stall_len = 4;
      m1(16'h0347);
      wait_writes(s + 6, 200);
      compare_writes(s, base, 6);
      check_eq("bp_gap", 32'(wq_cyc[s+2] - wq_cyc[s+1]), 32'd7);
      stall_idx = -1;
      tick(1);
      exit_done(d0, a0);

      // random loads with random ack delays
      rand_ack = 1'b1;
      repeat (3) begin
         fill_random();
         len = int'($urandom_range(1, DEPTH));
         s = wq_addr.size(); d0 = done_cnt; a0 = abort_cnt;
         base = 16'($urandom); load_base = base;
         tape_len = 5'(len);
         m1(16'h0347);
         wait_writes(s + len, 400);
         tick(2);
         compare_writes(s, base, len);
         exit_done(d0, a0);
      end
      rand_ack = 1'b0;

      // empty image
      s = wq_addr.size(); d0 = done_cnt; a0 = abort_cnt;
      tape_len = '0;
      m1(16'h0347);
      check_eq("empty_busy", 32'(busy), 32'd1);
      cpu_addr = 16'h0348;
      #1;
      check_eq("empty_p1", 32'(patch_data), 32'h37);
      tick(5);
      check_eq("empty_nwr", 32'(wq_addr.size() - s), 32'd0);
      exit_done(d0, a0);

      // abort while a delayed write is in flight
      fill_random();
      s = wq_addr.size(); d0 = done_cnt; a0 = abort_cnt;
      base = 16'h5000; load_base = base; tape_len = 5'd8;
      stall_idx = s + 1; stall_len = 3;
      m1(16'h0347);
      wait_writes(s + 1, 50);
      w = 0;
      while (!ram_we && w < 20) begin
         tick(1);
         w++;
      end
      check_eq("abort_we_seen", 32'(ram_we), 32'd1);
      m1(16'h1000);
      tick(10);
      stall_idx = -1;
      compare_writes(s, base, 2);
      check_eq("abort_pulse", 32'(abort_cnt - a0), 32'd1);
      check_eq("abort_nodone", 32'(done_cnt - d0), 32'd0);
      check_eq("abort_we", 32'(ram_we), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);

      // wrap, with re-trap and tape_ready drop mid-load
      s = wq_addr.size(); d0 = done_cnt; a0 = abort_cnt;
      load_base = 16'hFFFE; tape_len = 5'd4;
      m1(16'h0347);
      tape_ready = 1'b0;
      wait_writes(s + 1, 50);
      m1(16'h0347);
      wait_writes(s + 4, 100);
      tick(2);
      compare_writes(s, 16'hFFFE, 4);
      tape_ready = 1'b1;
      exit_done(d0, a0);

      // full image
      fill_random();
      s = wq_addr.size(); d0 = done_cnt; a0 = abort_cnt;
      base = 16'($urandom); load_base = base;
      tape_len = 5'(DEPTH);
      m1(16'h0347);
      wait_writes(s + DEPTH, 200);
      tick(2);
      compare_writes(s, base, DEPTH);
      check_eq("full_rd_last", 32'(tape_rd_addr), 32'(DEPTH - 1));
      exit_done(d0, a0);

      // reset during WAIT of byte 2, then restart from byte 0
      fill_random();
      s = wq_addr.size();
      base = 16'h6000; load_base = base; tape_len = 5'd6;
      m1(16'h0347);
      wait_writes(s + 2, 50);
      tick(1);
      reset_n = 1'b0;
      tick(1);
      check_reset_vals("midrst");
      reset_n = 1'b1;
      tick(1);
      s = wq_addr.size(); d0 = done_cnt; a0 = abort_cnt;
      m1(16'h0347);
      wait_writes(s + 6, 100);
      tick(2);
      compare_writes(s, base, 6);
      exit_done(d0, a0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/tape_dma_loader.md
# tape_dma_loader

Parametrised fast tape loader for the ZX80/ZX81 cores. It traps the CPU at the ROM LOAD entry point and substitutes a short spin-loop patch for the fetched opcodes. While the CPU spins, it copies a tape image from the on-chip tape buffer into system RAM through a write handshake. When the copy finishes, it releases the CPU to a programmable return address. It sits between the CPU address/M1 bus, the tape buffer BRAM and the SDRAM write port, and replaces the fixed-address loader logic in the top level.

## Interface
Parameters:
- TAPE_AW, 14, tape buffer address width (image ≤ 2^TAPE_AW bytes)
- RAM_AW, 16, destination RAM address width

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- cpu_addr  in  16  CPU address bus
- cpu_m1_n  in  1  CPU M1, active-low
- trap_addr  in  16  ROM LOAD entry (ZX81 0x0347, ZX80 0x0207)
- trap_end  in  16  first address past the ROM LOAD routine (ZX81 0x03C3, ZX80 0x024D)
- return_addr  in  16  JP target after load (ZX81 0x0207, ZX80 0x0203)
- load_base  in  RAM_AW  RAM address of tape byte 0
- tape_len  in  TAPE_AW+1  number of valid tape bytes
- tape_ready  in  1  tape buffer holds an unconsumed image
- tape_rd_addr  out  TAPE_AW  tape BRAM read address
- tape_rd_data  in  8  tape BRAM data, valid 1 clk after address
- ram_wr_addr  out  RAM_AW  RAM write address
- ram_wr_data  out  8  RAM write data
- ram_we  out  1  write request, held until acked
- ram_ack  in  1  write accepted this cycle
- patch_sel  out  1  CPU memory read must take patch_data instead of ROM
- patch_data  out  8  patch byte for the current cpu_addr
- busy  out  1  FSM not IDLE
- done  out  1  1-clk pulse: image fully loaded and CPU left the trap window
- aborted  out  1  1-clk pulse: CPU left the trap window before the load completed

## Operation
- M1 edge: cpu_m1_n registered; an edge is old=1, new=0. All trap/exit decisions are taken only on M1 edges.
- Trap window: trap_addr ≤ cpu_addr < trap_end (unsigned).
- Patch: 7 bytes at offset k = cpu_addr − trap_addr, k = 0..6.
  - Bytes: AF, P1, 30, FD, C3, return_addr[7:0], return_addr[15:8].
  - P1 = 00 (NOP) in states other than DONE; P1 = 37 (SCF) in DONE.
  - patch_sel = busy & (k < 7), combinational; patch_data = 00 when patch_sel = 0.
- FSM states: IDLE, FETCH, WAIT, WRITE, DONE.
  - IDLE: on an M1 edge with cpu_addr == trap_addr and tape_ready = 1, clear cnt to 0. Go to DONE if tape_len == 0, else to FETCH.
  - FETCH: tape_rd_addr ← cnt; go to WAIT.
  - WAIT: capture tape_rd_data into ram_wr_data; ram_wr_addr ← load_base + cnt, truncated to RAM_AW (wraps); ram_we ← 1; go to WRITE.
  - WRITE: hold ram_we, ram_wr_addr and ram_wr_data stable until ram_ack.
    - On ack: ram_we ← 0 and cnt ← cnt + 1.
    - If cnt + 1 == tape_len, go to DONE; else go to FETCH.
  - DONE: P1 = SCF. On an M1 edge outside the trap window, pulse done and go to IDLE.
- Early exit: an M1 edge outside the trap window in FETCH, WAIT or WRITE sets abort_pend.
  - In FETCH or WAIT, go to IDLE on the next clk.
  - In WRITE, go to IDLE on ack; the in-flight write completes and is never dropped mid-handshake.
  - aborted pulses on entry to IDLE. No further writes are issued.
- Re-trap: an M1 edge at trap_addr while busy is ignored; the load is not restarted.
- tape_ready is sampled only in IDLE. Deassertion mid-load has no effect.

## Timing
- Reset (reset_n = 0 at a clk edge):
  - State IDLE; cnt = 0.
  - tape_rd_addr = 0, ram_wr_addr = 0, ram_wr_data = 0.
  - ram_we = 0, busy = 0, done = 0, aborted = 0, abort_pend = 0, old M1 = 1.
  - Reset mid-transfer drops ram_we in the same cycle.
- Trap latency: M1 edge registered → IDLE exit 1 clk later. busy and patch_sel are valid for the opcode read of the trap fetch in the same M1 cycle; the CPU read occurs ≥2 clk after the M1 fall at 52 MHz.
- Per byte, minimum 3 clk (FETCH, WAIT, WRITE with ack in the same cycle); each extra cycle without ram_ack adds 1 clk.
- ram_ack while ram_we = 0 is ignored.
- done and aborted are exactly 1 clk wide and never asserted together.
- cnt width is TAPE_AW+1, so tape_len = 2^TAPE_AW is loadable.

## Test plan
- ZX81 .p load: trap 0x0347, end 0x03C3, ret 0x0207, base 0x4009, len 5, ram_ack always 1.
  - Required: writes 0x4009..0x400D with bytes 0..4, 3 clk apart.
  - Patch byte at 0x0348 = 00 during the load and 37 after.
  - CPU fetch at 0x0207 → done pulse; busy = 0.
- Backpressure: ram_ack low for 4 clk on byte 2 → ram_we, ram_wr_addr and ram_wr_data held constant; no byte skipped or duplicated.
- Empty image: tape_len 0, trap hit → DONE immediately, zero writes, P1 = 37.
- Abort: M1 fetch at 0x1000 while in WRITE with ack delayed 3 clk → pending write completes, then aborted pulse, no further ram_we.
- Wrap and full: RAM_AW 16, base 0xFFFE, len 4 → addresses FFFE, FFFF, 0000, 0001. Separately, len 2^TAPE_AW loads all bytes, and the last tape_rd_addr equals all-ones.
- Reset mid-load (reset_n low for 1 clk during WAIT) → all outputs are at their reset values next clk, and a later trap restarts from tape byte 0.
